tone_player: RTL and testbench
==============================

TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BEAT_CYCLES, default 12_500_000, cycles per length unit (1/8 s).
REQ-003 SHALL have parameter GAP_CYCLES, default 1_000_000, silent cycles after each note (10 ms).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: block enable; low aborts any note and holds IDLE.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to play the note on the inputs.
REQ-008 SHALL have port octave, input, 2 bits: 0 low, 1 mid, 2 high, 3 treated as mid.
REQ-009 SHALL have port note, input, 3 bits: 0 rest, 1..7 = do..si.
REQ-010 SHALL have port length, input, 3 bits: duration code, TONE time = (length+1)*BEAT_CYCLES.
REQ-011 SHALL have port full_note, output, 5 bits: {latched octave, latched note} of the current/last note.
REQ-012 SHALL have port buzzer, output, 1 bit: square-wave drive to the buzzer.
REQ-013 SHALL have port busy, output, 1 bit: high in TONE and GAP.
REQ-014 SHALL have port over, output, 1 bit: one-cycle pulse when a note completes normally.

Function
REQ-015 SHALL implement FSM IDLE -> TONE -> GAP -> IDLE.
REQ-016 SHALL, in IDLE with en=1 and start=1 at edge k, latch octave/note/length, enter TONE at k+1, busy=1 from k+1.
REQ-017 SHALL ignore start while busy=1; latched values remain unchanged.
REQ-018 SHALL map octave 3 to 1 at latch time; full_note reflects the mapped value.
REQ-019 SHALL use mid-octave half-period H(n) = floor(CLK_HZ/(2*f)), f = 262,294,330,349,392,440,494 Hz for n=1..7.
REQ-020 SHALL use half-period H<<1 for octave 0, H for octave 1, H>>1 for octave 2; counter width SHALL hold 2*H(1) without overflow.
REQ-021 SHALL, in TONE, start buzzer=0 with a zero toggle counter and toggle buzzer when the counter reaches half-period-1, then reset the counter.
REQ-022 SHALL hold buzzer=0 for the whole TONE when note=0 (rest); timing is otherwise unchanged.
REQ-023 SHALL stay in TONE for exactly (length+1)*BEAT_CYCLES cycles, then enter GAP.
REQ-024 SHALL hold buzzer=0 in GAP for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-025 SHALL assert over for exactly one cycle, the first IDLE cycle after GAP, with busy=0 in that cycle.
REQ-026 SHALL allow start in the same cycle that over is high; the new note begins the next cycle.
REQ-027 SHALL, when en=0, return to IDLE on the next edge: buzzer=0, busy=0, and no over pulse.
REQ-028 SHALL, when en=0 and start=1 are simultaneous, not start the note (en wins).
REQ-029 SHALL keep full_note at the last latched value in IDLE.

Reset
REQ-030 SHALL, on rst=1, immediately force state IDLE, buzzer=0, busy=0, over=0, full_note=0, and clear all counters, including mid-note.
REQ-031 SHALL ignore start while rst=1; the first start is accepted on the first edge after rst deasserts.

Verification
REQ-032 SHALL cover: CLK_HZ=52400, BEAT=10, GAP=4; start with oct=1, note=1, len=1 at edge k -> busy k+1..k+24; buzzer toggles every 100 cycles; over only at k+25.
REQ-033 SHALL cover: note=0, len=0 -> buzzer=0 throughout; over exactly 15 cycles after the start edge; full_note=5'b01000.
REQ-034 SHALL cover: oct=2, note=1 gives half-period 50; oct=0 gives 200; oct=3 gives 100 with full_note[4:3]=1.
REQ-035 SHALL cover: start pulsed mid-TONE -> ignored; full_note unchanged; over timing unchanged.
REQ-036 SHALL cover: en dropped mid-TONE -> next cycle busy=0 and buzzer=0; no over; a later start plays normally.
REQ-037 SHALL cover: rst asserted mid-GAP -> outputs 0 asynchronously; start in the first cycle after release is accepted; back-to-back start on the over cycle is accepted.

Source files
------------

// File: rtl/tone_player.sv
`default_nettype none
// ============================================================================
// tone_player : plays one latched note as a buzzer square wave, then a gap.
// Rev 1.0
// ============================================================================
module tone_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [1:0] octave,
  input  logic [2:0] note,
  input  logic [2:0] length,
  output logic [4:0] full_note,
  output logic       buzzer,
  output logic       busy,
  output logic       over
);

  localparam int H1 = CLK_HZ / (2 * 262);
  localparam int H2 = CLK_HZ / (2 * 294);
  localparam int H3 = CLK_HZ / (2 * 330);
  localparam int H4 = CLK_HZ / (2 * 349);
  localparam int H5 = CLK_HZ / (2 * 392);
  localparam int H6 = CLK_HZ / (2 * 440);
  localparam int H7 = CLK_HZ / (2 * 494);
  localparam int CW = $clog2(2 * H1 + 1);
  localparam int DW = $clog2(8 * BEAT_CYCLES + GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] tone_cnt;
  logic [DW-1:0] dur_cnt;
  logic [CW-1:0] base_half;
  logic [CW-1:0] half;
  logic [1:0]    oct_mapped;
  logic [DW-1:0] tone_last;

  // Half-period derives from the latched note so it stays fixed for the whole TONE.
  always_comb begin
    case (full_note[2:0])
      3'd2:    base_half = CW'(H2);
      3'd3:    base_half = CW'(H3);
      3'd4:    base_half = CW'(H4);
      3'd5:    base_half = CW'(H5);
      3'd6:    base_half = CW'(H6);
      3'd7:    base_half = CW'(H7);
      default: base_half = CW'(H1);
    endcase
  end

  always_comb begin
    case (full_note[4:3])
      2'd0:    half = base_half << 1;
      2'd2:    half = base_half >> 1;
      default: half = base_half;
    endcase
  end

  assign oct_mapped = (octave == 2'd3) ? 2'd1 : octave;
  assign tone_last  = (DW'(length) + DW'(1)) * DW'(BEAT_CYCLES) - DW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tone_cnt  <= '0;
      dur_cnt   <= '0;
      full_note <= '0;
      buzzer    <= 1'b0;
      busy      <= 1'b0;
      over      <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      over     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          over <= 1'b0;
          if (start) begin
            full_note <= {oct_mapped, note};
            dur_cnt   <= tone_last;
            tone_cnt  <= '0;
            buzzer    <= 1'b0;
            busy      <= 1'b1;
            state     <= TONE;
          end
        end
        TONE: begin
          if (dur_cnt == '0) begin
            state    <= GAP;
            dur_cnt  <= DW'(GAP_CYCLES - 1);
            tone_cnt <= '0;
            buzzer   <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt - DW'(1);
            if (tone_cnt == half - CW'(1)) begin
              tone_cnt <= '0;
              buzzer   <= (full_note[2:0] != 3'd0) & ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + CW'(1);
            end
          end
        end
        GAP: begin
          if (dur_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            over  <= 1'b1;
          end else begin
            dur_cnt <= dur_cnt - DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          over  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_player.sv
`default_nettype none
// tb_tone_player : directed plus randomized stimulus against an elapsed-time
// reference model of one note (TONE then GAP then an over cycle).
module tb_tone_player;

  localparam int CLK_HZ = 52400;
  localparam int BEAT   = 10;
  localparam int GAP    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [1:0] octave = '0;
  logic [2:0] note = '0;
  logic [2:0] length = '0;
  logic [4:0] full_note;
  logic       buzzer;
  logic       busy;
  logic       over;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tone_player #(
    .CLK_HZ      (CLK_HZ),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .octave    (octave),
    .note      (note),
    .length    (length),
    .full_note (full_note),
    .buzzer    (buzzer),
    .busy      (busy),
    .over      (over)
  );

  // Reference model: a note is described by its elapsed cycle count m_t
  // since the accepting edge (1 = first TONE cycle).
  int         freq [8] = '{262, 262, 294, 330, 349, 392, 440, 494};
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_tone = 0;
  int         m_half = 1;
  logic [2:0] m_note = '0;
  logic [4:0] m_full = '0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int half_of(input int o, input int n);
    int h;
    h = CLK_HZ / (2 * freq[n]);
    if (o == 0) return h * 2;
    if (o == 2) return h / 2;
    return h;
  endfunction

  task automatic model_edge();
    logic [1:0] mo;
    if (rst) begin
      m_active = 1'b0;
      m_full   = '0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if ((!m_active || m_t == m_tone + GAP + 1) && start) begin
      mo       = (octave == 2'd3) ? 2'd1 : octave;
      m_full   = {mo, note};
      m_note   = note;
      m_tone   = (int'(length) + 1) * BEAT;
      m_half   = half_of(int'(mo), int'(note));
      m_active = 1'b1;
      m_t      = 1;
    end else if (m_active) begin
      m_t++;
      if (m_t > m_tone + GAP + 1) m_active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int eb, eo, ez;
    eb = (m_active && m_t <= m_tone + GAP) ? 1 : 0;
    eo = (m_active && m_t == m_tone + GAP + 1) ? 1 : 0;
    ez = (m_active && m_note != 3'd0 && m_t <= m_tone && ((m_t - 1) / m_half) % 2 == 1) ? 1 : 0;
    check("busy", int'(busy), eb);
    check("over", int'(over), eo);
    check("buzzer", int'(buzzer), ez);
    check("full_note", int'(full_note), int'(m_full));
  endtask

  task automatic step(input bit e, input bit s, input logic [1:0] o,
                      input logic [2:0] n, input logic [2:0] l);
    en = e; start = s; octave = o; note = n; length = l;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 2'd0, 3'd0, 3'd0);
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_over", int'(over), 0);
    check("rst_buzzer", int'(buzzer), 0);
    check("rst_full_note", int'(full_note), 0);
    m_active = 1'b0;
    m_full   = '0;
    @(negedge clk);
  endtask

  initial begin
    // Reset held: starts ignored, outputs zero.
    step(1'b1, 1'b1, 2'd1, 3'd1, 3'd1);
    step(1'b1, 1'b1, 2'd2, 3'd5, 3'd0);
    rst = 1'b0;

    // Mid-octave do, length 1: 24 busy cycles then over.
    step(1'b1, 1'b1, 2'd1, 3'd1, 3'd1);
    idle(26);

    // Rest, length 0; back-to-back start on the over cycle.
    step(1'b1, 1'b1, 2'd1, 3'd0, 3'd0);
    idle(14);
    step(1'b1, 1'b1, 2'd2, 3'd1, 3'd7);
    idle(20);
    // Start pulsed mid-TONE is ignored.
    step(1'b1, 1'b1, 2'd0, 3'd6, 3'd2);
    idle(80);

    // Octave 0 and octave 3 (mapped to mid).
    step(1'b1, 1'b1, 2'd0, 3'd1, 3'd7);
    idle(86);
    step(1'b1, 1'b1, 2'd3, 3'd7, 3'd7);
    idle(86);

    // Enable dropped mid-TONE, then a normal note.
    step(1'b1, 1'b1, 2'd2, 3'd3, 3'd5);
    idle(45);
    step(1'b0, 1'b0, 2'd0, 3'd0, 3'd0);
    step(1'b0, 1'b1, 2'd1, 3'd2, 3'd0);
    step(1'b1, 1'b1, 2'd1, 3'd5, 3'd7);
    idle(86);

    // Async reset mid-GAP; start on the first edge after release.
    step(1'b1, 1'b1, 2'd1, 3'd1, 3'd0);
    idle(11);
    async_reset_check();
    step(1'b1, 1'b1, 2'd1, 3'd4, 3'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 2'd2, 3'd1, 3'd7);
    idle(59);
    // Async reset mid-TONE while the buzzer is high.
    async_reset_check();
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
